// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer: op encodings,
// FSM state type and the divide-by-zero LO value.
package muldiv_pkg;
  localparam int XLEN = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] DIV0_LO = '1;
endpackage

// File: rtl/muldiv_step.sv
// One iteration of the muldiv datapath: shift-add for multiply, restoring
// trial-subtract-shift for divide. Purely combinational.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             isDiv,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] accNext,
  output logic [WIDTH-1:0] lowNext
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    sum     = {1'b0, acc} + (low[0] ? {1'b0, operand} : '0);
    shifted = {acc, low[WIDTH-1]};
    trial   = shifted - {1'b0, operand};
    accNext = sum[WIDTH:1];
    lowNext = {sum[0], low[WIDTH-1:1]};
    if (isDiv) begin
      // Remainder is always below the divisor, so WIDTH+1 bits never overflow.
      if (!trial[WIDTH]) begin
        accNext = trial[WIDTH-1:0];
        lowNext = {low[WIDTH-2:0], 1'b1};
      end else begin
        accNext = shifted[WIDTH-1:0];
        lowNext = {low[WIDTH-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller owning HI/LO.
// Optional MULDIV_FAST_MUL_EN: multiplies bypass RUN with a one-cycle product.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_srcA,
  input  logic [WIDTH-1:0] i_srcB,
  input  logic             i_cancel,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_hilo_rdD,
  output logic             o_busy,
  output logic             o_stall_req,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [1:0]       o_dbgState
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, stateNext;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, low, opnd, stepAcc, stepLow;
  logic             isDivReg, negRes, negRem, divZero;
  logic [WIDTH-1:0] hiReg, loReg;
  logic             busy, done, dbz;

  logic             startOk, fastMul, fixWrite;
  logic             signedOp, aNeg, bNeg;
  logic [WIDTH-1:0] aMag, bMag, fixHi, fixLo;
  logic [2*WIDTH-1:0] prodMag, prodFix;

  // Handshake: i_start is taken only in IDLE and only without i_cancel; there
  // is no ready, the hazard logic stalls on o_stall_req instead.
  assign startOk  = (state == S_IDLE) && i_start && !i_cancel;
  assign fixWrite = (state == S_FIXUP) && !i_cancel;
  assign signedOp = ~i_op[0];
  assign aNeg     = signedOp & i_srcA[WIDTH-1];
  assign bNeg     = signedOp & i_srcB[WIDTH-1];
  assign aMag     = aNeg ? -i_srcA : i_srcA;
  assign bMag     = bNeg ? -i_srcB : i_srcB;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fastProd;
  assign fastMul  = ~i_op[1];
  assign fastProd = {{WIDTH{1'b0}}, aMag} * {{WIDTH{1'b0}}, bMag};
`else
  assign fastMul = 1'b0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .isDiv   (isDivReg),
    .acc     (acc),
    .low     (low),
    .operand (opnd),
    .accNext (stepAcc),
    .lowNext (stepLow)
  );

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:  if (startOk) stateNext = fastMul ? S_FIXUP : S_RUN;
      S_RUN:   if (count == CW'(1)) stateNext = S_FIXUP;
      S_FIXUP: stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
    if (i_cancel) stateNext = S_IDLE;
  end

  always_comb begin
    prodMag = {acc, low};
    prodFix = negRes ? -prodMag : prodMag;
    fixHi   = prodFix[2*WIDTH-1:WIDTH];
    fixLo   = prodFix[WIDTH-1:0];
    if (isDivReg) begin
      // On divide by zero the dividend magnitude was frozen in low.
      if (divZero) begin
        fixHi = negRem ? -low : low;
        fixLo = WIDTH'(DIV0_LO);
      end else begin
        fixHi = negRem ? -acc : acc;
        fixLo = negRes ? -low : low;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      acc      <= '0;
      low      <= '0;
      opnd     <= '0;
      isDivReg <= 1'b0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
      divZero  <= 1'b0;
      hiReg    <= '0;
      loReg    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      state <= stateNext;
      busy  <= (stateNext != S_IDLE);
      done  <= fixWrite;
      dbz   <= fixWrite & isDivReg & divZero;
      if (startOk) begin
        isDivReg <= i_op[1];
        negRes   <= aNeg ^ bNeg;
        negRem   <= aNeg;
        divZero  <= i_op[1] && (i_srcB == '0);
        count    <= CW'(WIDTH);
        acc      <= '0;
        low      <= i_op[1] ? aMag : bMag;
        opnd     <= i_op[1] ? bMag : aMag;
`ifdef MULDIV_FAST_MUL_EN
        if (fastMul) {acc, low} <= fastProd;
`endif
      end else if (state == S_RUN) begin
        count <= count - CW'(1);
        if (!divZero) begin
          acc <= stepAcc;
          low <= stepLow;
        end
      end
      if (fixWrite) begin
        hiReg <= fixHi;
        loReg <= fixLo;
      end else if (state == S_IDLE) begin
        if (i_mthi) hiReg <= i_wdata;
        if (i_mtlo) loReg <= i_wdata;
      end
    end
  end

  assign o_busy        = busy;
  assign o_stall_req   = busy & i_hilo_rdD;
  assign o_done        = done;
  assign o_div_by_zero = dbz;
  assign o_hi          = hiReg;
  assign o_lo          = loReg;
  assign o_dbgState    = state;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: random and directed MULT/DIV ops
// checked against plain 64-bit arithmetic; monitor compares on o_done.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic         clk, rst_n;
  logic         start, cancel, mthi, mtlo, hilo_rd;
  logic [1:0]   op;
  logic [W-1:0] srcA, srcB, wdata;
  logic         o_busy, o_stall_req, o_done, o_div_by_zero;
  logic [W-1:0] o_hi, o_lo;
  logic [1:0]   o_dbgState;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [2*W:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] model_hi, model_lo;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_op          (op),
    .i_srcA        (srcA),
    .i_srcB        (srcB),
    .i_cancel      (cancel),
    .i_mthi        (mthi),
    .i_mtlo        (mtlo),
    .i_wdata       (wdata),
    .i_hilo_rdD    (hilo_rd),
    .o_busy        (o_busy),
    .o_stall_req   (o_stall_req),
    .o_done        (o_done),
    .o_div_by_zero (o_div_by_zero),
    .o_hi          (o_hi),
    .o_lo          (o_lo),
    .o_dbgState    (o_dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: {div_by_zero, HI, LO}
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      OP_MULT:  begin p = sa * sb; return {1'b0, p}; end
      OP_MULTU: begin p = ua * ub; return {1'b0, p}; end
      OP_DIV: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {1'b0, sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {1'b0, ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        check("result", {o_div_by_zero, o_hi, o_lo}, exp_q.pop_front());
        check("done_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
    if (rst_n && o_div_by_zero && !o_done) begin
      vectors++;
      miscompares++;
      $display("FAIL dbz_without_done: got div_by_zero=1 done=0 expected div_by_zero=0");
    end
  end

  // driver: called at a negedge, returns at the negedge where o_done is high
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic rd, input logic poke_mtlo);
    logic [2*W:0] e;
    int lat;
    e = model(o, a, b);
    lat = o[1] ? W + 1 : MUL_LAT;
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + 1 + lat);
    start = 1'b1; op = o; srcA = a; srcB = b; hilo_rd = rd;
    @(negedge clk);
    start = 1'b0; srcA = $urandom; srcB = $urandom;
    for (int i = 0; i < lat; i++) begin
      check("busy", o_busy, 1);
      check("stall", o_stall_req, rd);
      if (poke_mtlo && i == 0) begin mtlo = 1'b1; wdata = 32'h1234; end
      if (poke_mtlo && i == 1) check("mtlo_busy_ignored", o_lo, model_lo);
      @(negedge clk);
      mtlo = 1'b0;
    end
    check("busy_end", o_busy, 0);
    check("stall_idle", o_stall_req, 0);
    hilo_rd = 1'b0;
    model_hi = e[2*W-1:W];
    model_lo = e[W-1:0];
  endtask

  logic [1:0]   r_op;
  logic [W-1:0] r_a, r_b;

  initial begin
    rst_n = 1'b0; start = 0; cancel = 0; mthi = 0; mtlo = 0; hilo_rd = 0;
    op = 0; srcA = 0; srcB = 0; wdata = 0;
    model_hi = '0; model_lo = '0;
    #12;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_dbz", o_div_by_zero, 0);
    check("rst_hilo", {o_hi, o_lo}, 0);
    check("rst_state", o_dbgState, S_IDLE);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // directed
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(OP_MULT, -32'sd7, 32'd3, 1'b1, 1'b0);
    do_op(OP_DIV, -32'sd7, 32'd2, 1'b1, 1'b0);
    do_op(OP_DIVU, 32'd100, 32'd0, 1'b0, 1'b0);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
    do_op(OP_DIV, 32'd7, -32'sd2, 1'b0, 1'b1);
    @(negedge clk);

    // MTLO / MTHI while idle
    mtlo = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_idle", o_lo, 32'h1234);
    model_lo = 32'h1234;
    mthi = 1'b1; wdata = $urandom;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_idle", o_hi, wdata);
    model_hi = wdata;

    // cancel and start together: cancel wins
    start = 1'b1; cancel = 1'b1; op = OP_DIVU; srcA = 32'd9; srcB = 32'd3;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_start_busy", o_busy, 0);
    check("cancel_start_state", o_dbgState, S_IDLE);

    // cancel at busy cycle 10, then immediate restart
    start = 1'b1; op = OP_DIV; srcA = $urandom; srcB = 32'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      check("cancel_pre_busy", o_busy, 1);
      if (i == 10) cancel = 1'b1;
      @(negedge clk);
    end
    cancel = 1'b0;
    check("cancel_busy", o_busy, 0);
    check("cancel_done", o_done, 0);
    check("cancel_hilo", {o_hi, o_lo}, {model_hi, model_lo});
    do_op(OP_MULTU, 32'd12345, 32'd6789, 1'b1, 1'b0);

    // randomized, partly back-to-back
    for (int n = 0; n < 30; n++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a = $urandom;
      case ($urandom_range(0, 3))
        0: r_b = $urandom_range(0, 5);
        1: r_b = -$urandom_range(1, 5);
        2: r_b = $urandom_range(0, 65535);
        default: r_b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) r_a = 32'h8000_0000;
      do_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // asynchronous reset mid-RUN
    start = 1'b1; op = OP_MULTU; srcA = $urandom; srcB = $urandom; hilo_rd = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", o_busy, 0);
    check("arst_stall", o_stall_req, 0);
    check("arst_done", o_done, 0);
    check("arst_hilo", {o_hi, o_lo}, 0);
    @(negedge clk);
    rst_n = 1'b1; hilo_rd = 1'b0;
    model_hi = '0; model_lo = '0;
    @(negedge clk);
    check("post_rst_state", o_dbgState, S_IDLE);
    check("post_rst_hilo", {o_hi, o_lo}, {model_hi, model_lo});
    do_op(OP_DIVU, 32'd1000, 32'd7, 1'b0, 1'b0);

    // drain
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller for the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU from the EX stage, runs a shift-add or restoring-divide sequence over multiple cycles, and owns the HI/LO registers. It raises a stall request so the hazard logic can freeze fetch and decode and flush EX while a dependent MFHI/MFLO or a second multiply/divide waits.

## Interface
- WIDTH, 32, operand/HI/LO width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  EX-stage muldiv op valid, sampled when idle
- i_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- i_srcA  in  WIDTH  multiplicand / dividend
- i_srcB  in  WIDTH  multiplier / divisor
- i_cancel  in  1  abort in-flight op (EX flush)
- i_mthi, i_mtlo  in  1  direct HI/LO write strobes
- i_wdata  in  WIDTH  MTHI/MTLO data
- i_hilo_rdD  in  1  decode stage holds MFHI/MFLO or a muldiv op
- o_busy  out  1  sequence in flight (registered)
- o_stall_req  out  1  to hazard logic: o_busy & i_hilo_rdD
- o_done  out  1  one-cycle pulse, HI/LO just updated
- o_div_by_zero  out  1  pulses with o_done on divide by zero
- o_hi, o_lo  out  WIDTH  HI/LO register contents

## Operation
- FSM states: IDLE, RUN, FIXUP.
- IDLE: i_start latches operands. Signed ops store magnitudes plus result and remainder sign bits. Counter loads WIDTH. Next state is RUN.
- RUN, multiply: each cycle, if multiplier LSB is set, add the multiplicand to the upper accumulator half (WIDTH+1-bit add with carry), then shift the {acc, multiplier} pair right by 1.
- RUN, divide: restoring divide. Shift {rem, quot} left 1, trial-subtract the divisor (WIDTH+1 bits), keep the result if it is non-negative and set the quotient bit.
- RUN: counter decrements; at 0, go to FIXUP.
- FIXUP: apply signs. MULT negates the 2*WIDTH product. DIV negates the quotient if signs differ and gives the remainder the dividend's sign. Write HI/LO (HI = high product / remainder, LO = low product / quotient). Next state is IDLE.
- Divide by zero: HI = i_srcA, LO = all ones, o_div_by_zero = 1.
- Signed divide of 0x80000000 by -1: LO = 0x80000000, HI = 0.
- i_start while busy: ignored; the hazard logic guarantees no second start.
- i_mthi/i_mtlo while idle: write HI/LO at the next edge. While busy: ignored.
- i_cancel: from any state go to IDLE; HI/LO keep their previous values; no o_done.
- i_cancel and i_start in the same cycle while idle: cancel wins, no start.
- Reset: state IDLE, counter 0, HI/LO 0, o_busy/o_done/o_div_by_zero 0.

## Timing
- Edge 0 samples i_start.
- o_busy is high from after edge 0 until after edge WIDTH+1 (WIDTH RUN cycles plus 1 FIXUP cycle).
- HI/LO update at edge WIDTH+1. o_done and o_div_by_zero are high for the following cycle.
- Back-to-back: a new i_start is accepted in the cycle o_done is high.
- o_stall_req is combinational from the registered o_busy and i_hilo_rdD; no combinational path from i_start.
- Reset asserted mid-operation clears everything immediately; no o_done.

## Configuration
- MULDIV_FAST_MUL_EN defined: MULT/MULTU skip RUN. IDLE goes straight to FIXUP using a single-cycle WIDTH×WIDTH product. o_busy is high for 1 cycle, and o_done pulses 2 cycles after start.
- Not defined: multiply uses the iterative path (WIDTH+1 busy cycles).
- Divide is always iterative.

## Structure
- Shared package muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state typedef: S_IDLE, S_RUN, S_FIXUP
  - DIV0_LO constant
- One sub-module, muldiv_step: combinational single-iteration datapath (add-shift or trial-subtract-shift). The FSM, counter, sign handling and HI/LO registers live in muldiv_sequencer.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 busy cycles HI = 0xFFFFFFFE, LO = 0x00000001, o_done one pulse.
- MULT -7 × 3 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; with MULDIV_FAST_MUL_EN, the same result after 1 busy cycle.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 0 -> HI = 100, LO = 0xFFFFFFFF, o_div_by_zero pulses.
- DIV start, i_cancel at busy cycle 10 -> o_busy falls next edge, HI/LO unchanged, no o_done. Next start is accepted immediately.
- i_hilo_rdD held high during DIV -> o_stall_req high exactly while o_busy. i_mtlo with 0x1234 while busy is ignored; while idle, LO = 0x1234 next edge.
- Reset asserted mid-RUN -> all outputs 0 asynchronously. After release, HI/LO = 0 and state IDLE.
